// File: rtl/sequence_input_checker_pkg.sv
// Shared definitions for the memory-game player input checker.
//   SEQ_AW            sequence memory address width (also score width)
//   TILE0..TILE3      tile codes
//   EASY/NORMAL/HARD  sequence lengths used by level select
//   chk_state_t       checker FSM state encoding
//   low_key_tile      tile code of the lowest-numbered key held low
//   multi_key_low     1 when more than one key is held low
package sequence_input_checker_pkg;

    localparam int SEQ_AW = 6;

    localparam logic [1:0] TILE0 = 2'd0;
    localparam logic [1:0] TILE1 = 2'd1;
    localparam logic [1:0] TILE2 = 2'd2;
    localparam logic [1:0] TILE3 = 2'd3;

    localparam logic [4:0] EASY   = 5'd3;
    localparam logic [4:0] NORMAL = 5'd6;
    localparam logic [4:0] HARD   = 5'd9;

    localparam logic [3:0] KEYS_RELEASED = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_DATA,
        ST_WAIT_PRESS,
        ST_FEEDBACK,
        ST_RELEASE,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

    // Only meaningful when at least one key is low; all-released maps to TILE3.
    function automatic logic [1:0] low_key_tile(input logic [3:0] keys_n);
        if (!keys_n[0])      return TILE0;
        else if (!keys_n[1]) return TILE1;
        else if (!keys_n[2]) return TILE2;
        else                 return TILE3;
    endfunction

    function automatic logic multi_key_low(input logic [3:0] keys_n);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (!keys_n[i]) n++;
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/sequence_input_checker_key_sync_edge.sv
// Key synchroniser and press detector, shared with level select.
//   clock, resetn  system clock, synchronous active-low reset
//   key_n          asynchronous active-low tile keys
//   press          1-cycle pulse: keys left the all-released state
//   press_tile     tile code of the pressed key, valid with press
//   press_multi    more than one key low at the press, valid with press
//   keys_idle      synchronised keys are all released
// press appears 3 cycles after the key_n edge: two synchroniser flops plus
// the registered edge detect.
module sequence_input_checker_key_sync_edge
    import sequence_input_checker_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] key_n,
    output logic       press,
    output logic [1:0] press_tile,
    output logic       press_multi,
    output logic       keys_idle
);

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync_prev;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1       <= KEYS_RELEASED;
            sync2       <= KEYS_RELEASED;
            sync_prev   <= KEYS_RELEASED;
            press       <= 1'b0;
            press_tile  <= TILE0;
            press_multi <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            sync_prev   <= sync2;
            // Only a transition out of all-released counts, so a key held
            // across states never produces a second press.
            press       <= (sync2 != KEYS_RELEASED) && (sync_prev == KEYS_RELEASED);
            press_tile  <= low_key_tile(sync2);
            press_multi <= multi_key_low(sync2);
        end
    end

    assign keys_idle = (sync2 == KEYS_RELEASED);

endmodule

// File: rtl/sequence_input_checker.sv
// Player-side sequence checker: reads the stored sequence back one entry at a
// time, checks each key press against it, requests a feedback flash of the
// pressed tile and reports pass/fail.
//   clock, resetn  system clock, synchronous active-low reset
//   start          pulse: begin checking (ignored while busy)
//   difficulty     number of entries to check, sampled on start
//   key_n          asynchronous active-low tile keys
//   seq_rd_addr    sequence memory address; seq_rd_data valid one cycle later
//   fb_req/fb_tile feedback flash request, held until fb_ack
//   busy           not idle
//   pass/fail      1-cycle result pulses
//   score          correct presses in the current round
//
// state      | meaning
// IDLE       | waiting for start
// FETCH      | seq_rd_addr presents entry idx
// WAIT_DATA  | capture expected tile, clear timeout counter
// WAIT_PRESS | wait for a single-key press or timeout
// FEEDBACK   | fb_req high until fb_ack
// RELEASE    | wait for all keys released, then judge the press
// PASS       | pass pulse
// FAIL       | fail pulse
module sequence_input_checker
    import sequence_input_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 150_000_000,
    parameter int TO_W           = 28
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [4:0]        difficulty,
    input  logic [3:0]        key_n,
    output logic [SEQ_AW-1:0] seq_rd_addr,
    input  logic [1:0]        seq_rd_data,
    output logic              fb_req,
    output logic [1:0]        fb_tile,
    input  logic              fb_ack,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [SEQ_AW-1:0] score
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    chk_state_t        state;
    chk_state_t        state_nxt;
    logic [SEQ_AW-1:0] idx;
    logic [SEQ_AW-1:0] idx_inc;
    logic [4:0]        diff_r;
    logic [1:0]        expected;
    logic [1:0]        fb_tile_r;
    logic [TO_W-1:0]   to_cnt;
    logic              press;
    logic [1:0]        press_tile;
    logic              press_multi;
    logic              keys_idle;

    sequence_input_checker_key_sync_edge u_keys (
        .clock       (clock),
        .resetn      (resetn),
        .key_n       (key_n),
        .press       (press),
        .press_tile  (press_tile),
        .press_multi (press_multi),
        .keys_idle   (keys_idle)
    );

    assign idx_inc = idx + 1'b1;

    always_ff @(posedge clock) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (start) state_nxt = (difficulty == 5'd0) ? ST_PASS : ST_FETCH;
            ST_FETCH:      state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA:  state_nxt = ST_WAIT_PRESS;
            ST_WAIT_PRESS: begin
                // A press in the final cycle still wins over the timeout.
                if (press)                  state_nxt = press_multi ? ST_FAIL : ST_FEEDBACK;
                else if (to_cnt == TO_LAST) state_nxt = ST_FAIL;
            end
            ST_FEEDBACK:   if (fb_ack) state_nxt = ST_RELEASE;
            ST_RELEASE: begin
                if (keys_idle) begin
                    if (fb_tile_r != expected)             state_nxt = ST_FAIL;
                    else if (idx_inc == SEQ_AW'(diff_r))   state_nxt = ST_PASS;
                    else                                   state_nxt = ST_FETCH;
                end
            end
            ST_PASS:       state_nxt = ST_IDLE;
            ST_FAIL:       state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            idx       <= '0;
            score     <= '0;
            diff_r    <= 5'd0;
            expected  <= TILE0;
            fb_tile_r <= TILE0;
            to_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        score  <= '0;
                        diff_r <= difficulty;
                    end
                end
                ST_WAIT_DATA: begin
                    expected <= seq_rd_data;
                    to_cnt   <= '0;
                end
                ST_WAIT_PRESS: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (press && !press_multi) fb_tile_r <= press_tile;
                end
                ST_RELEASE: begin
                    if (keys_idle && (fb_tile_r == expected)) begin
                        score <= score + 1'b1;
                        idx   <= idx_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // idx is only updated in IDLE and RELEASE, so it is stable through FETCH.
    assign seq_rd_addr = idx;
    assign fb_tile     = fb_tile_r;
    assign fb_req      = (state == ST_FEEDBACK);
    assign busy        = (state != ST_IDLE);
    assign pass        = (state == ST_PASS);
    assign fail        = (state == ST_FAIL);

endmodule

// File: tb/tb_sequence_input_checker.sv
module tb_sequence_input_checker;
    import sequence_input_checker_pkg::*;

    localparam int TO = 20;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [4:0]        difficulty = 5'd0;
    logic [3:0]        key_n = 4'hF;
    logic [SEQ_AW-1:0] seq_rd_addr;
    logic [1:0]        seq_rd_data = 2'd0;
    logic              fb_req;
    logic [1:0]        fb_tile;
    logic              fb_ack = 1'b0;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [SEQ_AW-1:0] score;

    int checks = 0;
    int failures = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;
    int fbreq_rise = 0;
    bit both_seen = 1'b0;
    logic fb_req_d = 1'b0;

    logic [1:0] mem [64];
    int press_q[$];
    int fb_obs_q[$];

    sequence_input_checker #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .difficulty  (difficulty),
        .key_n       (key_n),
        .seq_rd_addr (seq_rd_addr),
        .seq_rd_data (seq_rd_data),
        .fb_req      (fb_req),
        .fb_tile     (fb_tile),
        .fb_ack      (fb_ack),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .score       (score)
    );

    always #5 clock = ~clock;

    always @(posedge clock) seq_rd_data <= mem[seq_rd_addr];

    always @(negedge clock) begin
        if (pass) pass_cnt++;
        if (fail) fail_cnt++;
        if (pass && fail) both_seen = 1'b1;
        if (fb_req && !fb_req_d) fbreq_rise++;
        fb_req_d = fb_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [4:0] d);
        difficulty = d;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic press_key(input int t);
        int n;
        n = 0;
        key_n = ~(4'b0001 << t);
        while (!fb_req && n < 40) begin
            tick(1);
            n++;
        end
        if (fb_req) begin
            fb_obs_q.push_back(int'(fb_tile));
            tick(int'($urandom_range(0, 3)));
            fb_ack = 1'b1;
            tick(1);
            fb_ack = 1'b0;
        end else begin
            fb_obs_q.push_back(-1);
        end
        tick(int'($urandom_range(0, 2)));
        key_n = 4'hF;
        tick(8);
    endtask

    task automatic press_multi(input int code);
        case (code)
            4:       key_n = 4'b1010;
            5:       key_n = 4'b0011;
            default: key_n = 4'b0000;
        endcase
        tick(6);
        key_n = 4'hF;
        tick(6);
    endtask

    task automatic run_round(input int diff);
        int n;
        fb_obs_q.delete();
        pulse_start(5'(diff));
        tick(4);
        fb_ack = 1'b1;
        tick(1);
        fb_ack = 1'b0;
        foreach (press_q[i]) begin
            if (press_q[i] >= 4) press_multi(press_q[i]);
            else                 press_key(press_q[i]);
        end
        n = 0;
        while (busy && n < 100) begin
            tick(1);
            n++;
        end
    endtask

    // Press i is judged against entry i; the round ends at the first multi-key
    // or wrong press (fail) or when diff presses have matched (pass). Every
    // single-key press gets a feedback flash of the pressed tile.
    function automatic void model_round(input int diff, output int e_score,
                                        output bit e_pass, output int e_fb);
        bit done;
        done = (diff == 0);
        e_score = 0;
        e_pass = (diff == 0);
        e_fb = 0;
        for (int i = 0; i < press_q.size() && !done; i++) begin
            if (press_q[i] >= 4) begin
                done = 1'b1;
            end else begin
                e_fb++;
                if (press_q[i] != int'(mem[i])) begin
                    done = 1'b1;
                end else begin
                    e_score++;
                    if (e_score == diff) begin
                        e_pass = 1'b1;
                        done = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        tick(3);
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (pass !== 1'b0)   begin failures++; $display("FAIL reset_pass: got %b want 0", pass); end
        checks++; if (fail !== 1'b0)   begin failures++; $display("FAIL reset_fail: got %b want 0", fail); end
        checks++; if (fb_req !== 1'b0) begin failures++; $display("FAIL reset_fb_req: got %b want 0", fb_req); end
        checks++; if (score !== '0)    begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
        checks++; if (seq_rd_addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d want 0", seq_rd_addr); end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_sequences();
        int diff, e_score, e_fb, p0, f0, r0, r;
        bit e_pass;
        for (int rnd = 0; rnd < 14; rnd++) begin
            press_q.delete();
            for (int i = 0; i < 64; i++) mem[i] = 2'($urandom_range(0, 3));
            case (rnd)
                0: begin diff = 3; mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; press_q = '{2, 0, 3}; end
                1: begin diff = 3; mem[0] = 2'd1; mem[1] = 2'd1; mem[2] = 2'd2; press_q = '{1, 3}; end
                2: begin diff = 3; press_q = '{4}; end
                default: begin
                    if (rnd == 3)      diff = int'(EASY);
                    else if (rnd == 4) diff = int'(NORMAL);
                    else if (rnd == 5) diff = int'(HARD);
                    else               diff = int'($urandom_range(1, 9));
                    for (int k = 0; k < diff; k++) begin
                        r = int'($urandom_range(0, 9));
                        if (r < 7) begin
                            press_q.push_back(int'(mem[k]));
                        end else begin
                            if (r < 9) press_q.push_back((int'(mem[k]) + int'($urandom_range(1, 3))) % 4);
                            else       press_q.push_back(int'($urandom_range(4, 6)));
                            break;
                        end
                    end
                end
            endcase
            model_round(diff, e_score, e_pass, e_fb);
            p0 = pass_cnt; f0 = fail_cnt; r0 = fbreq_rise;
            run_round(diff);
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seq%0d_done: busy=%b want 0", rnd, busy); end
            checks++; if (pass_cnt - p0 != int'(e_pass)) begin failures++; $display("FAIL seq%0d_pass: pulses %0d want %0d", rnd, pass_cnt - p0, e_pass); end
            checks++; if (fail_cnt - f0 != int'(!e_pass)) begin failures++; $display("FAIL seq%0d_fail: pulses %0d want %0d", rnd, fail_cnt - f0, !e_pass); end
            checks++; if (int'(score) != e_score) begin failures++; $display("FAIL seq%0d_score: got %0d want %0d", rnd, score, e_score); end
            checks++; if (fbreq_rise - r0 != e_fb) begin failures++; $display("FAIL seq%0d_fb_count: got %0d want %0d", rnd, fbreq_rise - r0, e_fb); end
            for (int i = 0; i < fb_obs_q.size() && i < e_fb; i++) begin
                checks++;
                if (fb_obs_q[i] !== press_q[i]) begin
                    failures++;
                    $display("FAIL seq%0d_fb_tile%0d: got %0d want %0d", rnd, i, fb_obs_q[i], press_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int f0;
        f0 = fail_cnt;
        pulse_start(5'd3);
        for (int k = 1; k <= 22; k++) begin
            tick(1);
            if (k == 21) begin
                checks++; if (fail !== 1'b0) begin failures++; $display("FAIL timeout_early: fail=%b want 0 at cycle %0d", fail, k); end
            end
            if (k == 22) begin
                checks++; if (fail !== 1'b1) begin failures++; $display("FAIL timeout_edge: fail=%b want 1 at cycle %0d", fail, k); end
            end
        end
        tick(3);
        checks++; if (fail_cnt - f0 != 1) begin failures++; $display("FAIL timeout_pulses: got %0d want 1", fail_cnt - f0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_round();
        int n, p0, f0;
        for (int i = 0; i < 64; i++) mem[i] = TILE1;
        fb_obs_q.delete();
        pulse_start(5'd3);
        tick(4);
        press_key(1);
        key_n = 4'b1101;
        n = 0;
        while (!fb_req && n < 40) begin tick(1); n++; end
        checks++; if (fb_req !== 1'b1) begin failures++; $display("FAIL rstmid_feedback: fb_req=%b want 1", fb_req); end
        checks++; if (score !== SEQ_AW'(1)) begin failures++; $display("FAIL rstmid_score_before: got %0d want 1", score); end
        p0 = pass_cnt; f0 = fail_cnt;
        resetn = 1'b0;
        tick(1);
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (fb_req !== 1'b0) begin failures++; $display("FAIL rstmid_fb_req: got %b want 0", fb_req); end
        checks++; if (score !== '0)    begin failures++; $display("FAIL rstmid_score: got %0d want 0", score); end
        key_n = 4'hF;
        resetn = 1'b1;
        tick(4);
        checks++; if (pass_cnt != p0 || fail_cnt != f0) begin failures++; $display("FAIL rstmid_no_result: pass+%0d fail+%0d want 0", pass_cnt - p0, fail_cnt - f0); end
        pulse_start(5'd0);
        checks++; if (pass !== 1'b1) begin failures++; $display("FAIL diff0_pass: got %b want 1", pass); end
        tick(1);
        checks++; if (pass !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL diff0_after: pass=%b busy=%b want 0 0", pass, busy); end
    endtask

    task automatic test_held_key();
        int p0, f0, r0;
        for (int i = 0; i < 64; i++) mem[i] = TILE2;
        fb_obs_q.delete();
        key_n = 4'b1011;
        tick(4);
        p0 = pass_cnt; f0 = fail_cnt; r0 = fbreq_rise;
        pulse_start(5'd1);
        tick(3);
        pulse_start(5'd0);
        tick(1);
        checks++; if (fbreq_rise != r0) begin failures++; $display("FAIL held_no_press: fb_req rises %0d want 0", fbreq_rise - r0); end
        checks++; if (busy !== 1'b1 || pass_cnt != p0) begin failures++; $display("FAIL held_start_ignored: busy=%b pass+%0d want 1 0", busy, pass_cnt - p0); end
        key_n = 4'hF;
        tick(3);
        press_key(2);
        checks++; if (pass_cnt - p0 != 1 || fail_cnt != f0) begin failures++; $display("FAIL held_result: pass+%0d fail+%0d want 1 0", pass_cnt - p0, fail_cnt - f0); end
        checks++; if (score !== SEQ_AW'(1)) begin failures++; $display("FAIL held_score: got %0d want 1", score); end
        checks++; if (fb_obs_q.size() != 1 || fb_obs_q[0] != 2) begin failures++; $display("FAIL held_fb_tile: got %0d entries want tile 2", fb_obs_q.size()); end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (both_seen) begin failures++; $display("FAIL pass_fail_overlap: seen=%b want 0", both_seen); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = TILE0;
        test_reset();
        test_sequences();
        test_timeout();
        test_reset_mid_round();
        test_held_key();
        test_no_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
